// File: rtl/zmod_adc_spi_arbiter.sv
// zmod_adc_spi_arbiter: round-robin arbiter sharing one ZMOD ADC SPI engine with a busy watchdog
module zmod_adc_spi_arbiter #(
  parameter int N_REQ = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      i_req_valid,
  input  logic [24*N_REQ-1:0]   i24_req_cmd,
  output logic [N_REQ-1:0]      o_req_ready,
  output logic [N_REQ-1:0]      o_rsp_valid,
  output logic [7:0]            o8_rsp_data,
  output logic                  o_rsp_timeout,
  output logic [23:0]           o24_spi_cmd,
  output logic                  o_spi_start,
  input  logic                  i_spi_busy,
  input  logic [7:0]            i8_spi_rdata,
  output logic [1:0]            o2_owner,
  output logic                  o_busy
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, RESPOND} state_e;
  state_e state_q, state_d;
  logic [1:0] last_q, last_d, owner_q, owner_d, sel;
  logic [23:0] cmd_q, cmd_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic tmo_q, tmo_d, found, hit;
  assign hit = cnt_q == 16'(TIMEOUT_CYCLES - 1);
  // Scan farthest-to-nearest so the requester right after last wins
  always_comb begin
    sel = '0;
    found = 1'b0;
    for (int i = N_REQ; i >= 1; i--) begin
      if (i_req_valid[(int'(last_q) + i) % N_REQ]) begin
        sel = 2'((int'(last_q) + i) % N_REQ);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    owner_d = owner_q;
    cmd_d = cmd_q;
    cnt_d = cnt_q;
    data_d = data_q;
    tmo_d = tmo_q;
    o_req_ready = '0;
    o_rsp_valid = '0;
    o_spi_start = 1'b0;
    case (state_q)
      IDLE: if (found && !rst) begin
        o_req_ready = N_REQ'(1) << sel;
        owner_d = sel;
        cmd_d = i24_req_cmd[24*sel +: 24];
        state_d = ISSUE;
      end
      ISSUE: begin
        o_spi_start = 1'b1;
        cnt_d = '0;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        cnt_d = cnt_q + 16'd1;
        if (hit) begin
          tmo_d = 1'b1;
          data_d = 8'h00;
          state_d = RESPOND;
        end else if (i_spi_busy) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        cnt_d = cnt_q + 16'd1;
        // A fall on the terminal count still counts as a normal completion
        if (!i_spi_busy) begin
          data_d = cmd_q[23] ? i8_spi_rdata : 8'h00;
          state_d = RESPOND;
        end else if (hit) begin
          tmo_d = 1'b1;
          data_d = 8'h00;
          state_d = RESPOND;
        end
      end
      RESPOND: begin
        o_rsp_valid = N_REQ'(1) << owner_q;
        last_d = owner_q;
        tmo_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= 2'(N_REQ - 1);
      owner_q <= '0;
      cmd_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      owner_q <= owner_d;
      cmd_q <= cmd_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      tmo_q <= tmo_d;
    end
  end
  assign o24_spi_cmd = cmd_q;
  assign o2_owner = owner_q;
  assign o8_rsp_data = data_q;
  assign o_rsp_timeout = tmo_q;
  assign o_busy = state_q != IDLE;
endmodule

// File: tb/tb_zmod_adc_spi_arbiter.sv
// tb_zmod_adc_spi_arbiter: directed vectors, hand sequences and a randomized transaction model
module tb_zmod_adc_spi_arbiter;
  localparam int NR = 3;
  localparam int TO = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic [NR-1:0] req_valid = '0, req_ready, rsp_valid;
  logic [24*NR-1:0] req_cmd = '0;
  logic [7:0] rsp_data, spi_rdata = '0;
  logic rsp_timeout, spi_start, spi_busy = 1'b0, busy;
  logic [23:0] spi_cmd;
  logic [1:0] owner;
  int n_chk = 0, n_fail = 0;

  zmod_adc_spi_arbiter #(.N_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .i_req_valid(req_valid), .i24_req_cmd(req_cmd),
    .o_req_ready(req_ready), .o_rsp_valid(rsp_valid), .o8_rsp_data(rsp_data),
    .o_rsp_timeout(rsp_timeout), .o24_spi_cmd(spi_cmd), .o_spi_start(spi_start),
    .i_spi_busy(spi_busy), .i8_spi_rdata(spi_rdata), .o2_owner(owner), .o_busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got still running required finished");
    $fatal(1, "time limit");
  end

  typedef struct {
    logic [2:0]  mask;
    logic [71:0] cmds;
    int          a, b;
    logic [7:0]  rd;
    logic [2:0]  exp_ready;
    int          exp_lat;
    logic [7:0]  exp_data;
    logic        exp_to;
    logic [23:0] exp_cmd;
  } vec_t;

  function automatic vec_t mk(logic [2:0] m, logic [71:0] c, int a, int b, logic [7:0] rd,
                              logic [2:0] er, int lat, logic [7:0] d, logic t, logic [23:0] ec);
    vec_t v;
    v.mask = m; v.cmds = c; v.a = a; v.b = b; v.rd = rd;
    v.exp_ready = er; v.exp_lat = lat; v.exp_data = d; v.exp_to = t; v.exp_cmd = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; spi_busy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Grant cycle is t=0; busy is high for cycles a..a+b-1 counted from WAIT_HI entry (t=2)
  task automatic run_vec(input vec_t v);
    bit got = 0;
    int rel;
    @(negedge clk);
    req_valid = v.mask; req_cmd = v.cmds; spi_busy = 1'b0;
    #1;
    chk("vec_ready", req_ready, v.exp_ready);
    for (int t = 1; t <= 40 && !got; t++) begin
      @(negedge clk);
      req_valid = '0;
      rel = t - 2;
      spi_busy = rel >= v.a && rel < v.a + v.b;
      spi_rdata = rel >= v.a + v.b ? v.rd : ~v.rd;
      #1;
      if (t == 1) begin
        chk("vec_start", spi_start, 1);
        chk("vec_cmd", spi_cmd, v.exp_cmd);
      end
      if (rsp_valid != '0) begin
        got = 1;
        chk("vec_latency", t, v.exp_lat);
        chk("vec_rsp_owner", rsp_valid, v.exp_ready);
        chk("vec_rsp_data", rsp_data, v.exp_data);
        chk("vec_rsp_timeout", rsp_timeout, v.exp_to);
      end
    end
    chk("vec_rsp_seen", got, 1);
    spi_busy = 1'b0;
  endtask

  vec_t vecs[11];

  initial begin
    int g, rel, last_m, idle_from, tg, te, ta, tb_, tr, own;
    logic [23:0] tcmd;
    logic [7:0] trd, tdat;
    logic tto;
    logic [2:0] pend, infl, exp_rdy;
    logic [23:0] pc[NR];
    bit got;

    vecs[0]  = mk(3'b010, {24'h0, 24'h000A03, 24'h0}, 2, 10, 8'h55, 3'b010, 15, 8'h00, 0, 24'h000A03);
    vecs[1]  = mk(3'b001, {24'h0, 24'h0, 24'h800100}, 0, 3, 8'h8B, 3'b001, 6, 8'h8B, 0, 24'h800100);
    vecs[2]  = mk(3'b100, {24'h812345, 24'h0, 24'h0}, 100, 1, 8'h77, 3'b100, 18, 8'h00, 1, 24'h812345);
    vecs[3]  = mk(3'b010, {24'h0, 24'h8000FF, 24'h0}, 1, 100, 8'h66, 3'b010, 18, 8'h00, 1, 24'h8000FF);
    vecs[4]  = mk(3'b001, {24'h0, 24'h0, 24'h801234}, 5, 10, 8'hC3, 3'b001, 18, 8'hC3, 0, 24'h801234);
    vecs[5]  = mk(3'b100, {24'h805678, 24'h0, 24'h0}, 6, 10, 8'h3C, 3'b100, 18, 8'h00, 1, 24'h805678);
    vecs[6]  = mk(3'b111, {24'h000333, 24'h000222, 24'h800111}, 0, 1, 8'h99, 3'b001, 4, 8'h99, 0, 24'h800111);
    vecs[7]  = mk(3'b101, {24'h800444, 24'h000555, 24'h000666}, 3, 2, 8'hA5, 3'b100, 8, 8'hA5, 0, 24'h800444);
    vecs[8]  = mk(3'b011, {24'h0, 24'h800777, 24'h000888}, 1, 1, 8'h11, 3'b001, 5, 8'h00, 0, 24'h000888);
    vecs[9]  = mk(3'b110, {24'h800AAA, 24'h800BBB, 24'h0}, 0, 2, 8'h5A, 3'b010, 5, 8'h5A, 0, 24'h800BBB);
    vecs[10] = mk(3'b101, {24'h000CCC, 24'h0, 24'h800DDD}, 14, 1, 8'hE1, 3'b100, 18, 8'h00, 0, 24'h000CCC);

    // Reset values, with every requester valid to show ready stays low in reset
    req_valid = 3'b111; req_cmd = {3{24'hFFFFFF}};
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_spi_cmd", spi_cmd, 0);
    chk("rst_spi_start", spi_start, 0);
    chk("rst_owner", owner, 0);
    chk("rst_busy", busy, 0);
    req_valid = '0;
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Continuous requests from reset: grants rotate 0,1,2,0,1,2
    do_reset();
    infl = '0;
    for (int n = 0; n < 6; n++) begin
      got = 0;
      for (int w = 0; w < 10 && !got; w++) begin
        @(negedge clk);
        req_valid = ~infl; spi_busy = 1'b0;
        #1;
        if (req_ready != '0) begin
          got = 1;
          chk("rr_grant", req_ready, 3'b001 << (n % 3));
          infl = infl | (3'b001 << (n % 3));
        end
      end
      chk("rr_grant_seen", got, 1);
      got = 0;
      for (int w = 1; w < 20 && !got; w++) begin
        @(negedge clk);
        req_valid = ~infl; spi_busy = w == 2;
        #1;
        if (rsp_valid != '0) begin
          got = 1;
          chk("rr_rsp_owner", rsp_valid, 3'b001 << (n % 3));
          infl = infl & ~(3'b001 << (n % 3));
        end
      end
      chk("rr_rsp_seen", got, 1);
    end

    // Reset while waiting for busy to fall
    do_reset();
    @(negedge clk);
    req_valid = 3'b010; req_cmd = {24'h0, 24'h800123, 24'h0};
    #1;
    chk("mid_grant", req_ready, 3'b010);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    spi_busy = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; spi_busy = 1'b0;
    #1;
    chk("mid_busy_after", busy, 0);
    chk("mid_spi_cmd", spi_cmd, 0);
    chk("mid_owner", owner, 0);
    for (int w = 0; w < 4; w++) begin
      chk("mid_no_rsp", rsp_valid, 0);
      @(negedge clk);
      #1;
    end
    req_valid = 3'b111;
    #1;
    chk("mid_next_grant", req_ready, 3'b001);

    // Randomized traffic against a transaction-level model
    do_reset();
    last_m = NR - 1; idle_from = 0; tg = -100; te = -100; tr = -100; ta = 0; tb_ = 0; own = 0;
    tcmd = '0; trd = '0; tdat = '0; tto = 0; pend = '0; infl = '0;
    foreach (pc[k]) pc[k] = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int k = 0; k < NR; k++) begin
        if (!pend[k] && !infl[k]) begin
          if ($urandom_range(2) == 0) begin
            pend[k] = 1'b1;
            pc[k] = 24'($urandom);
          end
        end else if (pend[k] && $urandom_range(19) == 0) pend[k] = 1'b0;
        req_cmd[24*k +: 24] = pend[k] ? pc[k] : 24'($urandom);
      end
      req_valid = pend;
      rel = c - te;
      spi_busy = rel >= ta && rel < ta + tb_;
      spi_rdata = rel >= ta + tb_ ? trd : 8'($urandom);
      exp_rdy = '0;
      g = 0;
      if (c >= idle_from && pend != '0) begin
        for (int i = NR; i >= 1; i--) if (pend[(last_m + i) % NR]) g = (last_m + i) % NR;
        exp_rdy = 3'b001 << g;
        tg = c; te = c + 2;
        ta = $urandom_range(0, 18); tb_ = $urandom_range(1, 18);
        trd = 8'($urandom); tcmd = pc[g]; own = g; last_m = g;
        if (ta + tb_ > TO - 1) begin
          tr = te + TO; tto = 1; tdat = 8'h00;
        end else begin
          tr = te + ta + tb_ + 1; tto = 0; tdat = tcmd[23] ? trd : 8'h00;
        end
        idle_from = tr + 1;
      end
      #1;
      chk("rnd_ready", req_ready, exp_rdy);
      chk("rnd_start", spi_start, c == tg + 1);
      chk("rnd_busy", busy, c > tg && c <= tr);
      chk("rnd_rsp_valid", rsp_valid, c == tr ? 3'b001 << own : 3'b000);
      if (c == tr) begin
        chk("rnd_rsp_data", rsp_data, tdat);
        chk("rnd_rsp_timeout", rsp_timeout, tto);
        infl[own] = 1'b0;
      end
      if (c > tg && c <= tr) begin
        chk("rnd_spi_cmd", spi_cmd, tcmd);
        chk("rnd_owner", owner, own);
      end
      if (exp_rdy != '0) begin
        pend[g] = 1'b0;
        infl[g] = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
